// File: rtl/mod3709_pkg.sv
// Shared constants and types for the mod-3709 arithmetic datapath.
package mod3709_pkg;

  localparam int unsigned Q   = 3709;        // prime modulus
  localparam int unsigned W   = 12;          // operand/result width, ceil(log2 Q)
  localparam int unsigned QX2 = 2 * Q;       // compare point for the double subtract
  localparam int unsigned KW  = $clog2(W);   // multiplier bit counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod3709_csub.sv
// Conditional double subtract: reduces a value below 3Q into the range 0..Q-1.
module mod3709_csub
  import mod3709_pkg::*;
(
  input  logic [W+1:0] t_i,
  output logic [W-1:0] r_o
);

  localparam logic [W+1:0] Q_T   = (W+2)'(Q);
  localparam logic [W+1:0] QX2_T = (W+2)'(QX2);

  // Subtract 2Q or Q depending on which band the input falls into.
  always_comb begin
    // NOTE: r_o gets a value on every path, so no latch is inferred.
    r_o = t_i[W-1:0];
    if (t_i >= QX2_T) begin
      r_o = W'(t_i - QX2_T);
    end else if (t_i >= Q_T) begin
      r_o = W'(t_i - Q_T);
    end
  end

endmodule

// File: rtl/modmul_3709_seq.sv
// Sequential a*b mod 3709 using interleaved (Blakley) shift-add reduction,
// one multiplier bit per cycle, MSB first, with valid/ready on both sides.
module modmul_3709_seq
  import mod3709_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_c
);

  localparam logic [KW-1:0] K_LAST = KW'(W - 1);

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    acc_d;
  logic [KW-1:0]   k_q;
  logic [W-1:0]    out_c_q;
  logic [W+1:0]    t_d;
  logic [W-1:0]    a_red;
  logic [W-1:0]    b_red;

  // One Blakley step: double the accumulator and add a' when multiplier bit k is set.
  always_comb begin
    t_d = {1'b0, acc_q, 1'b0};
    if (b_q[k_q]) begin
      t_d = t_d + {2'b00, a_q};
    end
  end

  // Step reduction: t < 3Q, so at most two subtractions of Q are needed.
  mod3709_csub u_step (
    .t_i (t_d),
    .r_o (acc_d)
  );

  // Operand pre-reduction: inputs are below 2Q, so the top bits are zero.
  mod3709_csub u_pre_a (
    .t_i ({2'b00, in_a}),
    .r_o (a_red)
  );

  mod3709_csub u_pre_b (
    .t_i ({2'b00, in_b}),
    .r_o (b_red)
  );

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: operand registers are reset too, so nothing stale can leak into a result.
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= K_LAST;
      out_c_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_red;
            b_q     <= b_red;
            acc_q   <= '0;
            k_q     <= K_LAST;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          if (k_q == '0) begin
            out_c_q <= acc_d;
            k_q     <= K_LAST;
            state_q <= DONE;
          end else begin
            k_q <= k_q - KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_c     = out_c_q;

endmodule

// File: tb/tb_modmul_3709_seq.sv
// Self-checking bench for modmul_3709_seq: directed vectors, latency,
// back-pressure, mid-operation reset, throughput and a randomized run.
module tb_modmul_3709_seq;

  localparam int QMOD = 3709;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  modmul_3709_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c)
  );

  // Reference: plain modular arithmetic on the raw operands.
  function automatic int model(input int a, input int b);
    return (a * b) % QMOD;
  endfunction

  // in_ready and out_valid must never be high together.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (in_ready && out_valid) begin
        errors++;
        $display("FAIL handshake_exclusive: in_ready=%0b out_valid=%0b, required not both 1", in_ready, out_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and wait for it to be accepted; returns the accept edge time.
  task automatic accept(input int a, input int b, output time t_acc);
    int n;
    n = 0;
    t_acc = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end else begin
      in_a = 12'(a);
      in_b = 12'(b);
      in_valid = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Wait for out_valid; lat counts rising edges after the accept edge.
  task automatic wait_result(output logic [11:0] c, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
    c = out_c;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input int a, input int b, input int expected, input string name);
    time         t;
    logic [11:0] c;
    int          lat;
    accept(a, b, t);
    wait_result(c, lat);
    checks++;
    if (c !== 12'(expected)) begin
      errors++;
      $display("FAIL %s: %0d*%0d got %0d, required %0d", name, a, b, c, expected);
    end
    consume();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_c !== 12'd0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%0b out_valid=%0b out_c=%0d, required 1 0 0", in_ready, out_valid, out_c);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    time         t;
    logic [11:0] c;
    int          lat;
    accept(3708, 3708, t);
    wait_result(c, lat);
    checks++;
    if (lat != 12) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required 12", lat);
    end
    checks++;
    if (c !== 12'd1) begin
      errors++;
      $display("FAIL minus_one_squared: got %0d, required 1", c);
    end
    consume();
  endtask

  task automatic test_directed();
    run_op(1234, 2345, 710, "vec_1234x2345");
    run_op(0, 3708, 0, "vec_0x3708");
    run_op(2, 1855, 1, "vec_2x1855");
    run_op(4095, 1, 386, "prereduce_4095x1");
    run_op(3709, 3709, 0, "prereduce_3709x3709");
    run_op(1, 4095, 386, "prereduce_1x4095");
  endtask

  task automatic test_backpressure();
    time         t;
    logic [11:0] c0;
    int          lat;
    accept(100, 200, t);
    wait_result(c0, lat);
    checks++;
    if (c0 !== 12'(model(100, 200))) begin
      errors++;
      $display("FAIL bp_result: got %0d, required %0d", c0, model(100, 200));
    end
    for (int i = 0; i < 20; i++) begin
      in_a = 12'($urandom_range(0, 4095));
      in_b = 12'($urandom_range(0, 4095));
      in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_c !== c0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_valid=%0b in_ready=%0b out_c=%0d, required 1 0 %0d",
                 i, out_valid, in_ready, out_c, c0);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
    end
    run_op(9, 9, 81, "after_bp");
  endtask

  task automatic test_reset_mid_busy();
    time t;
    accept(3000, 3001, t);
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_c !== 12'd0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%0b in_ready=%0b out_c=%0d, required 0 1 0", out_valid, in_ready, out_c);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_partial_result cycle %0d: out_valid=%0b, required 0", i, out_valid);
      end
    end
    run_op(5, 7, 35, "after_reset_5x7");
  endtask

  task automatic test_back_to_back();
    time         t_acc [4];
    logic [11:0] c;
    int          lat;
    int          a [4];
    int          b [4];
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a[i] = $urandom_range(0, 4095);
      b[i] = $urandom_range(0, 4095);
      accept(a[i], b[i], t_acc[i]);
      wait_result(c, lat);
      checks++;
      if (c !== 12'(model(a[i], b[i]))) begin
        errors++;
        $display("FAIL b2b_result %0d: %0d*%0d got %0d, required %0d", i, a[i], b[i], c, model(a[i], b[i]));
      end
      if (i > 0) begin
        checks++;
        if (t_acc[i] - t_acc[i-1] != 140) begin
          errors++;
          $display("FAIL throughput %0d: accept spacing %0t, required 140 (14 cycles)", i, t_acc[i] - t_acc[i-1]);
        end
      end
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int edge_vals [5];
    int a;
    int b;
    int stall;
    time         t;
    logic [11:0] c;
    int          lat;
    edge_vals[0] = 0;
    edge_vals[1] = 1;
    edge_vals[2] = 3708;
    edge_vals[3] = 3709;
    edge_vals[4] = 4095;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom_range(0, 4095);
      b = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom_range(0, 4095);
      accept(a, b, t);
      wait_result(c, lat);
      checks++;
      if (c !== 12'(model(a, b))) begin
        errors++;
        $display("FAIL random %0d: %0d*%0d got %0d, required %0d", i, a, b, c, model(a, b));
      end
      stall = $urandom_range(0, 2);
      repeat (stall) tick();
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modmul_3709_seq.md
# modmul_3709_seq

Sequential modular multiplier that produces c = a·b mod 3709 for two 12-bit operands. It uses interleaved (Blakley) shift-add reduction, one multiplier bit per cycle. It sits upstream of the reduction path as the producer side of the mod-3709 arithmetic datapath and feeds residues to the downstream consumers. Valid/ready handshakes on both sides let it stall against back-pressure.

## Interface
- Q, 3709: modulus; fixed prime for this instance.
- W, 12: operand and result width; ceil(log2 Q).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- in_valid  input  1  operand pair present on in_a/in_b.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  W  multiplicand, 0..4095; values ≥ Q are accepted and pre-reduced.
- in_b  input  W  multiplier, 0..4095; values ≥ Q are accepted and pre-reduced.
- out_valid  output  1  out_c holds a valid result.
- out_ready  input  1  consumer accepts the result.
- out_c  output  W  result, always in 0..Q-1.

## Operation
- FSM has three states: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready, register a' = (in_a ≥ Q) ? in_a−Q : in_a.
  - Register b' the same way from in_b.
  - Clear acc, set bit counter k=W−1, go to BUSY.
- **BUSY**
  - in_ready=0.
  - Each cycle: t = 2·acc + (b'[k] ? a' : 0).
  - Then acc ← t reduced by up to two conditional subtractions of Q, using t<3Q.
  - k decrements. After the k=0 iteration, go to DONE.
- **DONE**
  - out_valid=1, out_c=acc, held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- **Widths**
  - a', b', acc: W bits.
  - t: W+2 bits. Max 2·3708+3708=11124 < 2^14.
  - One subtraction suffices for pre-reduction because 4095 < 2Q.
- **Reset**
  - Reset asserted in any state, including mid-BUSY, aborts the operation.
  - Next state is IDLE, acc=0, k=W−1, out_c=0.
  - No partial result is ever presented.
- **Illegal inputs**
  - In BUSY or DONE, in_valid is ignored.
  - in_a/in_b are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, out_c=0.
- Accept at rising edge 0, then 12 BUSY cycles (edges 1..12).
- out_valid rises after edge 12, so latency is 12 cycles from accept edge to out_valid high.
- With out_ready held high, throughput is one result per 14 cycles (accept, 12 BUSY, DONE handshake, IDLE).
- Back-pressure: DONE holds indefinitely; out_c stays constant while out_valid=1 && !out_ready.
- in_ready and out_valid are never high in the same cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- All outputs are registered or decoded from state only.

## Structure
- Shared package mod3709_pkg holds:
  - Q and W constants;
  - the state enum (IDLE, BUSY, DONE);
  - QX2 = 2·Q for the double-subtract compare.
- One natural sub-module, mod3709_csub: combinational W+2-bit → W-bit conditional double subtract.
  - It is instantiated once for the iteration step.
  - Pre-reduction reuses it with the top bits zeroed.
- Bit counter is $clog2(W) bits; the FSM is a single always block with async reset.

## Test plan
- 3708 × 3708 → out_c=1 (since (−1)² = 1), out_valid exactly 12 cycles after accept.
- 1234 × 2345 → out_c=710; 0 × 3708 → 0; 2 × 1855 → 1.
- 4095 × 1 → 386 (pre-reduction); 3709 × 3709 → 0.
- Back-pressure: out_ready low 20 cycles after DONE.
  - out_c is stable, in_ready=0, and a second in_valid is ignored.
  - The result transfers on the first out_ready-high edge.
- Reset pulse at BUSY cycle 6:
  - out_valid=0 and in_ready=1 immediately.
  - The next operation 5 × 7 → 35 is correct.
- Randomized run of 10^5 pairs checked against a software a·b mod 3709.
  - For pairs with a·b < 2^23, also cross-check against the existing combinational mod-3709 reducer fed with a·b.
